// File: rtl/serial_add_pkg.sv
// Shared constants for the bit-serial adder: state encoding and default operand width.
package serial_add_pkg;
  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/fa_nand_only.sv
// Full adder built only from 2-input NANDs: two NAND half adders plus a NAND OR-stage.
// Purely combinational, zero latency, no flow control.
module fa_nand_only (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);
  logic n_ab, x_a, x_b, s1;
  logic n_sc, y_s, y_c;

  // first half adder: n_ab is the inverted carry, s1 = a ^ b
  assign n_ab = ~(a & b);
  assign x_a  = ~(a & n_ab);
  assign x_b  = ~(b & n_ab);
  assign s1   = ~(x_a & x_b);

  assign n_sc = ~(s1 & cin);
  assign y_s  = ~(s1 & n_sc);
  assign y_c  = ~(cin & n_sc);
  assign s    = ~(y_s & y_c);

  // OR of the two half-adder carries, fed with their inverted forms
  assign co   = ~(n_ab & n_sc);
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one NAND full adder reused LSB first; out_valid rises WIDTH cycles after accept.
// Result held in DONE until out_ready; in_ready only in IDLE. SERIAL_ADD_OVF_EN adds a signed-overflow output.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fa_s, fa_co;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  fa_nand_only u_fa (
    .a   (a_sh_q[0]),
    .b   (b_sh_q[0]),
    .cin (carry_q),
    .s   (fa_s),
    .co  (fa_co)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    cnt_d    = cnt_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_RUN;
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        // shift form avoids a zero-width slice when WIDTH is 1
        sum_sh_d = (sum_sh_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
        carry_d  = fa_co;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
          sum_d   = sum_sh_d;
          cout_d  = fa_co;
`ifdef SERIAL_ADD_OVF_EN
          // carry_q is the carry into the MSB on this last bit
          ovf_d   = carry_q ^ fa_co;
`endif
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      cnt_q    <= cnt_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf       = ovf_q;
`endif
endmodule
